// File: rtl/memoria_pkg.sv
// Shared definitions for the memory-game turn controller: cell state
// encodings, the turn FSM states and the availability helper.
package memoria_pkg;

  localparam logic [3:0] HIDDEN    = 4'h0;
  localparam logic [3:0] CURSOR    = 4'hF;
  localparam logic [3:0] MATCH_P0  = 4'h9;
  localparam logic [3:0] MATCH_P1  = 4'hA;
  localparam logic [3:0] LABEL_MIN = 4'h1;
  localparam logic [3:0] LABEL_MAX = 4'h8;

  typedef enum logic [2:0] {
    PICK1,
    WAIT1,
    PICK2,
    WAIT2,
    JUDGE,
    SHOW,
    HIDE,
    DONE
  } ctrl_state_t;

  // A card can be picked or visited by the cursor only while it is face down
  function automatic logic is_available(input logic [3:0] state);
    return (state == HIDDEN) || (state == CURSOR);
  endfunction

endpackage

// File: rtl/memoria_next_avail.sv
// Combinational search for the next available cell after a given index,
// wrapping from the last cell back to cell 0. The starting cell itself is
// never returned; o_found is low when no other cell is available.
module memoria_next_avail
  import memoria_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int IDXW      = $clog2(NUM_CELLS)
) (
  input  logic [IDXW-1:0]      i_idx,
  input  logic [NUM_CELLS-1:0] i_avail,
  output logic [IDXW-1:0]      o_next,
  output logic                 o_found
);

  function automatic logic [IDXW-1:0] wrapAdd(input logic [IDXW-1:0] idx, input int off);
    int sum;
    sum = int'(idx) + off;
    if (sum >= NUM_CELLS) sum = sum - NUM_CELLS;
    return IDXW'(sum);
  endfunction

  // Scan from the farthest offset to the nearest so the nearest available cell wins
  always_comb begin
    o_next  = i_idx;
    o_found = 1'b0;
    for (int k = NUM_CELLS - 1; k >= 1; k--) begin
      if (i_avail[wrapAdd(i_idx, k)]) begin
        o_next  = wrapAdd(i_idx, k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memoria_turn_ctrl.sv
// Turn controller for the memory (pairs) game: moves the cursor over the
// card cells, reveals two picks per turn, judges them, and either claims
// the pair for the current player or hides it again and passes the turn.
module memoria_turn_ctrl
  import memoria_pkg::*;
#(
  parameter int NUM_CELLS   = 16,
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int IDXW        = $clog2(NUM_CELLS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_btn_next,
  input  logic                   i_btn_select,
  input  logic [4*NUM_CELLS-1:0] i_cell_state,
  output logic [NUM_CELLS-1:0]   o_cursor,
  output logic [NUM_CELLS-1:0]   o_select,
  output logic [NUM_CELLS-1:0]   o_par,
  output logic [NUM_CELLS-1:0]   o_claim,
  output logic                   o_claim_player,
  output logic                   o_player,
  output logic [3:0]             o_score0,
  output logic [3:0]             o_score1,
  output logic                   o_game_over
);

  localparam int TIMERW = $clog2(SHOW_CYCLES + 1);
  localparam int PAIRS  = NUM_CELLS / 2;

  ctrl_state_t r_state, w_stateNext;

  logic [IDXW-1:0]      r_cursorIdx, w_cursorNext;
  logic [IDXW-1:0]      r_firstIdx, w_firstNext;
  logic [IDXW-1:0]      r_secondIdx, w_secondNext;
  logic [3:0]           r_label1, w_label1Next;
  logic [TIMERW-1:0]    r_timer, w_timerNext;
  logic [NUM_CELLS-1:0] r_select, w_selectNext;
  logic [NUM_CELLS-1:0] r_par, w_parNext;
  logic [NUM_CELLS-1:0] r_claim, w_claimNext;
  logic                 r_claimPlayer, w_claimPlayerNext;
  logic                 r_player, w_playerNext;
  logic [3:0]           r_score0, w_score0Next;
  logic [3:0]           r_score1, w_score1Next;
  logic [4:0]           w_total;

  logic [3:0]           w_cells [NUM_CELLS];
  logic [NUM_CELLS-1:0] w_avail;
  logic [IDXW-1:0]      w_nextIdx;
  logic                 w_found;

  function automatic logic [NUM_CELLS-1:0] oneHot(input logic [IDXW-1:0] idx);
    logic [NUM_CELLS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] satInc(input logic [3:0] s);
    return (s == 4'hF) ? 4'hF : s + 4'd1;
  endfunction

  // Unpack the cell state bus and derive which cells can still be visited
  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      w_cells[i] = i_cell_state[4*i +: 4];
      w_avail[i] = is_available(w_cells[i]);
    end
  end

  // One search unit serves both the button-driven move and the auto-advance
  memoria_next_avail #(
    .NUM_CELLS(NUM_CELLS),
    .IDXW     (IDXW)
  ) u_nextAvail (
    .i_idx  (r_cursorIdx),
    .i_avail(w_avail),
    .o_next (w_nextIdx),
    .o_found(w_found)
  );

  // Next-state and next-register logic; labels are read only after the
  // revealed cell has had a full cycle to register its new state
  always_comb begin
    w_stateNext       = r_state;
    w_cursorNext      = r_cursorIdx;
    w_firstNext       = r_firstIdx;
    w_secondNext      = r_secondIdx;
    w_label1Next      = r_label1;
    w_timerNext       = r_timer;
    w_selectNext      = '0;
    w_parNext         = '0;
    w_claimNext       = '0;
    w_claimPlayerNext = r_claimPlayer;
    w_playerNext      = r_player;
    w_score0Next      = r_score0;
    w_score1Next      = r_score1;
    w_total           = '0;

    case (r_state)
      PICK1: begin
        if (i_btn_select) begin
          if (w_avail[r_cursorIdx]) begin
            w_selectNext = oneHot(r_cursorIdx);
            w_firstNext  = r_cursorIdx;
            w_stateNext  = WAIT1;
          end
        end else if (i_btn_next && w_found) begin
          w_cursorNext = w_nextIdx;
        end
      end
      WAIT1: begin
        if (w_found) w_cursorNext = w_nextIdx;
        w_stateNext = PICK2;
      end
      PICK2: begin
        if (i_btn_select) begin
          if (w_avail[r_cursorIdx] && (r_cursorIdx != r_firstIdx)) begin
            w_selectNext = oneHot(r_cursorIdx);
            w_secondNext = r_cursorIdx;
            w_stateNext  = WAIT2;
          end
        end else if (i_btn_next && w_found) begin
          w_cursorNext = w_nextIdx;
        end
      end
      WAIT2: begin
        w_label1Next = w_cells[r_firstIdx];
        w_stateNext  = JUDGE;
      end
      JUDGE: begin
        if (r_label1 == w_cells[r_secondIdx]) begin
          w_claimNext       = oneHot(r_firstIdx) | oneHot(r_secondIdx);
          w_claimPlayerNext = r_player;
          if (r_player) w_score1Next = satInc(r_score1);
          else          w_score0Next = satInc(r_score0);
          w_total = {1'b0, w_score0Next} + {1'b0, w_score1Next};
          if (w_total == 5'(PAIRS)) begin
            w_stateNext = DONE;
          end else begin
            w_stateNext = PICK1;
            if (w_found) w_cursorNext = w_nextIdx;
          end
        end else begin
          w_stateNext = SHOW;
          w_timerNext = TIMERW'(SHOW_CYCLES - 1);
        end
      end
      SHOW: begin
        if (r_timer == '0) begin
          w_parNext   = oneHot(r_firstIdx) | oneHot(r_secondIdx);
          w_stateNext = HIDE;
        end else begin
          w_timerNext = r_timer - 1'b1;
        end
      end
      HIDE: begin
        w_playerNext = ~r_player;
        w_stateNext  = PICK1;
      end
      DONE: begin
        w_stateNext = DONE;
      end
      default: w_stateNext = PICK1;
    endcase
  end

  // FSM state register; reset aborts any turn in progress
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= PICK1;
    else       r_state <= w_stateNext;
  end

  // Datapath registers: cursor, picks, timer, strobes, scores and player
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cursorIdx   <= '0;
      r_firstIdx    <= '0;
      r_secondIdx   <= '0;
      r_label1      <= HIDDEN;
      r_timer       <= '0;
      r_select      <= '0;
      r_par         <= '0;
      r_claim       <= '0;
      r_claimPlayer <= 1'b0;
      r_player      <= 1'b0;
      r_score0      <= '0;
      r_score1      <= '0;
    end else begin
      r_cursorIdx   <= w_cursorNext;
      r_firstIdx    <= w_firstNext;
      r_secondIdx   <= w_secondNext;
      r_label1      <= w_label1Next;
      r_timer       <= w_timerNext;
      r_select      <= w_selectNext;
      r_par         <= w_parNext;
      r_claim       <= w_claimNext;
      r_claimPlayer <= w_claimPlayerNext;
      r_player      <= w_playerNext;
      r_score0      <= w_score0Next;
      r_score1      <= w_score1Next;
    end
  end

  assign o_cursor       = oneHot(r_cursorIdx);
  assign o_select       = r_select;
  assign o_par          = r_par;
  assign o_claim        = r_claim;
  assign o_claim_player = r_claimPlayer;
  assign o_player       = r_player;
  assign o_score0       = r_score0;
  assign o_score1       = r_score1;
  assign o_game_over    = (r_state == DONE);

endmodule

// File: doc/memoria_turn_ctrl.md
Name: memoria_turn_ctrl

Overview:
- Game-side controller that drives the array of card cells in the memory (pairs) game and reads back their 4-bit states.
- Generates each cell's cursor-present, select and hide/clear strobes, plus claim strobes for matched pairs.
- Judges each two-card turn: equal labels give a match and the same player keeps the turn; unequal labels are shown for a while, hidden, and the turn passes.
- Sits between the debounced button inputs and the cell array; scores and the current player feed the display logic.

Parameters:
- NUM_CELLS, 16, number of card cells (even, ≤16).
- SHOW_CYCLES, 50_000_000, clk cycles a mismatched pair stays revealed before hiding.
- IDXW, $clog2(NUM_CELLS), cursor/index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_next  in  1  single-cycle pulse; advance cursor.
- btn_select  in  1  single-cycle pulse; pick card under cursor.
- cell_state  in  4*NUM_CELLS  packed cell states; cell i at [4i+3:4i].
- cursor  out  NUM_CELLS  one-hot, level; cell under cursor.
- select  out  NUM_CELLS  one-hot, 1-cycle strobe; reveal the picked cell.
- par  out  NUM_CELLS  1-cycle strobe; hide the flagged cells (mismatch).
- claim  out  NUM_CELLS  1-cycle strobe; flagged cells take the matched state of claim_player.
- claim_player  out  1  valid with claim; 0 gives MATCH_P0, 1 gives MATCH_P1.
- player  out  1  current player.
- score0, score1  out  4 each  pairs won per player.
- game_over  out  1  level; all pairs claimed.

Behaviour:
- Cell encodings (package): HIDDEN=4'h0, CURSOR=4'hF, MATCH_P0=4'h9, MATCH_P1=4'hA, labels 4'h1..4'h8.
- A cell is available when its state is HIDDEN or CURSOR.
- Reset (sync, high) values: cursor=1 at idx 0, select/par/claim=0, claim_player=0, player=0, scores=0, game_over=0, FSM=PICK1, show timer=0.
- Reset mid-turn aborts the turn; cells recover through their own reset.
- FSM states: PICK1, WAIT1, PICK2, WAIT2, JUDGE, SHOW, HIDE, DONE.
- PICK1/PICK2, btn_next: cursor moves to the next available index, wrapping NUM_CELLS-1 to 0. If no other cell is available, the cursor holds.
- PICK1/PICK2, btn_select: acts only if the cursor cell is available and, in PICK2, is not the first pick. It then drives select for exactly 1 cycle and latches the index (first_idx or second_idx). PICK1 goes to WAIT1; PICK2 goes to WAIT2.
- btn_select and btn_next in the same cycle: select wins and next is dropped.
- Buttons are ignored in every state other than PICK1/PICK2.
- WAIT1/WAIT2 last 1 cycle, so the cell registers its label. Then: latch label1 = cell_state[first_idx], or label2 = cell_state[second_idx]; WAIT1 goes to PICK2 and WAIT2 goes to JUDGE.
- In WAIT1 the cursor auto-advances to the next available cell. If none is available, it stays put.
- JUDGE, label1==label2:
  - claim strobes for both indices, claim_player=player.
  - The current player's score increments, saturating at 15.
  - player is unchanged.
  - Next state is DONE if total score == NUM_CELLS/2, else PICK1, with the cursor moved to the next available cell.
- JUDGE, labels differ: go to SHOW and load the timer with SHOW_CYCLES-1.
- SHOW: decrement the timer. At 0, go to HIDE.
- HIDE (1 cycle): par strobes both indices, player toggles, go to PICK1.
- DONE: game_over=1 and all strobes are 0. Only rst leaves DONE.
- Strobes are registered; latency from an accepted button to the strobe is 1 cycle.

Decomposition:
- Package memoria_pkg holds: the state encoding localparams (HIDDEN, CURSOR, MATCH_P0, MATCH_P1, LABEL_MIN=1, LABEL_MAX=8), the FSM enum ctrl_state_t, and the function is_available(logic[3:0]).
- Sub-module memoria_next_avail is combinational: from the current index and the availability vector, it gives the next available index with wrap, plus a found flag. It is shared by the cursor move and the auto-advance.

Test Plan:
- Reset then 3 btn_next → cursor one-hot moves 0→1→2→3. At idx 15, next wraps to 0. Unavailable cells (state 9/A) are skipped.
- Select idx 2 (label 5), then idx 7 (label 5):
  - select strobes 1 cycle each, 1 cycle after each button.
  - claim=bits 2 and 7, claim_player=0, score0=1, player stays 0.
- Select idx 0 (label 3), then idx 1 (label 4), with SHOW_CYCLES=4:
  - par=bits 0 and 1 exactly 5 cycles after JUDGE.
  - player becomes 1. Buttons pressed during SHOW have no effect.
- btn_select on the already-picked first cell in PICK2, and on a matched cell → no select strobe and no state change. btn_next and btn_select in the same cycle → select only, cursor unmoved.
- Claim all 8 pairs (NUM_CELLS=16) → game_over=1 after the final claim. Further buttons are ignored until rst, which clears scores, player and game_over in 1 cycle.
- rst asserted during SHOW → next cycle FSM=PICK1, timer=0, no par strobe, cursor at idx 0.
